// File: rtl/spi_ram_pkg.sv
// Shared definitions for the SPRAM <-> SPI RAM save/restore path: commands, flush FSM states,
// per-word timing constants and the word bit-reversal used to match the loader's bit order.
package spi_ram_pkg;

   localparam logic [7:0] SPI_CMD_WRITE = 8'h02;
   localparam logic [7:0] SPI_CMD_READ  = 8'h03;

   localparam int unsigned SHIFT_CYCLES       = 128;
   localparam int unsigned DESELECT_CYCLES    = 2;
   localparam int unsigned WRITE_WORD_CYCLES  = 132;
   localparam int unsigned VERIFY_WORD_CYCLES = 264;

   typedef enum logic [3:0] {
      StIdle,
      StFetch,
      StLoad,
      StShift,
      StDeselect,
      StRdLoad,
      StRdShift,
      StRdDeselect,
      StCheck
   } flush_state_t;

   // Bit 0 of the SPRAM word becomes the first data bit on the wire.
   function automatic logic [31:0] bitrev32(input logic [31:0] d);
      logic [31:0] r;
      for (int i = 0; i < 32; i++) begin
         r[i] = d[31 - i];
      end
      return r;
   endfunction

endpackage

// File: rtl/spi_shift_tx.sv
// 64-bit SPI mode-0 shifter at clk/2: load captures a frame and drops select, finish flags the
// high phase of the last bit. Bits sampled from miso on rising edges shift in at the LSB.
module spi_shift_tx
   import spi_ram_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic [63:0] load_data,
   input  logic        miso,
   output logic        spi_select,
   output logic        spi_clk_out,
   output logic        spi_mosi,
   output logic        finish,
   output logic [31:0] rx_data
);

   localparam logic [5:0] LastBit = 6'(SHIFT_CYCLES / 2 - 1);

   logic        active_q, active_d;
   logic        sclk_q, sclk_d;
   logic        rx_q, rx_d;
   logic [5:0]  cnt_q, cnt_d;
   logic [63:0] sr_q, sr_d;

   always_comb begin
      active_d = active_q;
      sclk_d   = sclk_q;
      rx_d     = rx_q;
      cnt_d    = cnt_q;
      sr_d     = sr_q;
      if (load) begin
         active_d = 1'b1;
         sclk_d   = 1'b0;
         cnt_d    = '0;
         sr_d     = load_data;
      end else if (active_q) begin
         if (!sclk_q) begin
            sclk_d = 1'b1;
            rx_d   = miso;
         end else begin
            // Falling edge: present the next bit and fold in the sampled one.
            sclk_d = 1'b0;
            sr_d   = {sr_q[62:0], rx_q};
            if (cnt_q == LastBit) begin
               active_d = 1'b0;
            end else begin
               cnt_d = cnt_q + 6'd1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         active_q <= 1'b0;
         sclk_q   <= 1'b0;
         rx_q     <= 1'b0;
         cnt_q    <= '0;
         sr_q     <= '0;
      end else begin
         active_q <= active_d;
         sclk_q   <= sclk_d;
         rx_q     <= rx_d;
         cnt_q    <= cnt_d;
         sr_q     <= sr_d;
      end
   end

   assign spi_select  = ~active_q;
   assign spi_clk_out = sclk_q;
   assign spi_mosi    = active_q & sr_q[63];
   assign finish      = active_q & sclk_q & (cnt_q == LastBit);
   assign rx_data     = sr_q[31:0];

endmodule

// File: rtl/spram_flush.sv
// Flushes the SPRAM region to external SPI RAM, one WRITE transaction per 32-bit word.
// Define SPRAM_FLUSH_VERIFY_EN to read back every word and flag the first mismatching address.
module spram_flush
   import spi_ram_pkg::*;
#(
   parameter int unsigned NUM_BYTES = 16384,
   parameter logic [23:0] BASE_ADDR = 24'h000000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   output logic        busy,
   output logic        done,
   output logic [15:0] spram_addr,
   input  logic [31:0] spram_rdat,
   input  logic        spi_miso,
   output logic        spi_select,
   output logic        spi_clk_out,
   output logic        spi_mosi
`ifdef SPRAM_FLUSH_VERIFY_EN
   ,
   output logic        verify_err,
   output logic [23:0] err_addr
`endif
);

   flush_state_t state_q, state_d;
   logic [16:0]  offset_q, offset_d;
   logic         done_q, done_d;
   logic         desel_q, desel_d;

   logic         tx_load;
   logic [63:0]  tx_data;
   logic         tx_finish;
   logic [31:0]  rx_data;
   logic [23:0]  word_addr;
   logic [16:0]  offset_inc;
   logic         last_word;
   logic         desel_last;

   assign word_addr  = BASE_ADDR + 24'(offset_q);
   assign offset_inc = offset_q + 17'd4;
   assign last_word  = (offset_inc == 17'(NUM_BYTES));
   assign desel_last = (desel_q == 1'(DESELECT_CYCLES - 1));

`ifdef SPRAM_FLUSH_VERIFY_EN
   logic [31:0] wr_word_q, wr_word_d;
   logic        verify_err_q, verify_err_d;
   logic [23:0] err_addr_q, err_addr_d;
`else
   logic unused_rx;
   assign unused_rx = ^{rx_data, spi_miso};
`endif

   always_comb begin
      state_d  = state_q;
      offset_d = offset_q;
      done_d   = done_q;
      desel_d  = desel_q;
      tx_load  = 1'b0;
      tx_data  = '0;
`ifdef SPRAM_FLUSH_VERIFY_EN
      wr_word_d    = wr_word_q;
      verify_err_d = verify_err_q;
      err_addr_d   = err_addr_q;
`endif
      case (state_q)
         StIdle: begin
            if (start) begin
               offset_d = '0;
               done_d   = 1'b0;
               state_d  = StFetch;
`ifdef SPRAM_FLUSH_VERIFY_EN
               verify_err_d = 1'b0;
               err_addr_d   = '0;
`endif
            end
         end
         StFetch: state_d = StLoad;
         StLoad: begin
            tx_load = 1'b1;
            tx_data = {SPI_CMD_WRITE, word_addr, bitrev32(spram_rdat)};
            state_d = StShift;
`ifdef SPRAM_FLUSH_VERIFY_EN
            wr_word_d = bitrev32(spram_rdat);
`endif
         end
         StShift: begin
            if (tx_finish) begin
               desel_d = 1'b0;
               state_d = StDeselect;
            end
         end
         StDeselect: begin
            if (!desel_last) begin
               desel_d = 1'b1;
            end else begin
`ifdef SPRAM_FLUSH_VERIFY_EN
               state_d = StRdLoad;
`else
               // Last tCSH cycle doubles as the next-word decision.
               if (last_word) begin
                  done_d  = 1'b1;
                  state_d = StIdle;
               end else begin
                  offset_d = offset_inc;
                  state_d  = StFetch;
               end
`endif
            end
         end
`ifdef SPRAM_FLUSH_VERIFY_EN
         StRdLoad: begin
            tx_load = 1'b1;
            tx_data = {SPI_CMD_READ, word_addr, 32'h0};
            state_d = StRdShift;
         end
         StRdShift: begin
            if (tx_finish) begin
               desel_d = 1'b0;
               state_d = StRdDeselect;
            end
         end
         StRdDeselect: begin
            if (!desel_last) begin
               desel_d = 1'b1;
            end else begin
               state_d = StCheck;
            end
         end
         StCheck: begin
            if ((rx_data != wr_word_q) && !verify_err_q) begin
               verify_err_d = 1'b1;
               err_addr_d   = word_addr;
            end
            if (last_word) begin
               done_d  = 1'b1;
               state_d = StIdle;
            end else begin
               offset_d = offset_inc;
               state_d  = StFetch;
            end
         end
`endif
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         offset_q <= '0;
         done_q   <= 1'b0;
         desel_q  <= 1'b0;
`ifdef SPRAM_FLUSH_VERIFY_EN
         wr_word_q    <= '0;
         verify_err_q <= 1'b0;
         err_addr_q   <= '0;
`endif
      end else begin
         state_q  <= state_d;
         offset_q <= offset_d;
         done_q   <= done_d;
         desel_q  <= desel_d;
`ifdef SPRAM_FLUSH_VERIFY_EN
         wr_word_q    <= wr_word_d;
         verify_err_q <= verify_err_d;
         err_addr_q   <= err_addr_d;
`endif
      end
   end

   spi_shift_tx u_shift (
      .clk         (clk),
      .rst         (rst),
      .load        (tx_load),
      .load_data   (tx_data),
      .miso        (spi_miso),
      .spi_select  (spi_select),
      .spi_clk_out (spi_clk_out),
      .spi_mosi    (spi_mosi),
      .finish      (tx_finish),
      .rx_data     (rx_data)
   );

   assign busy       = (state_q != StIdle);
   assign done       = done_q;
   assign spram_addr = offset_q[15:0];
`ifdef SPRAM_FLUSH_VERIFY_EN
   assign verify_err = verify_err_q;
   assign err_addr   = err_addr_q;
`endif

endmodule

// File: tb/tb_spram_flush.sv
// Directed bench for spram_flush: three instances (basic, address wrap, 64-word round trip)
// each with an SPRAM model and an SPI RAM slave model; honours SPRAM_FLUSH_VERIFY_EN.
module tb_spram_flush;

`ifdef SPRAM_FLUSH_VERIFY_EN
   localparam int W = 264;
`else
   localparam int W = 132;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] start;
   logic [2:0] busy, done, spi_select, spi_clk_out, spi_mosi;
   logic [31:0] spram_mem [0:2][0:63];

   int n_checks = 0;
   int n_fail   = 0;
   int overlap  = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : u
      localparam int unsigned NB = (g == 0) ? 16 : ((g == 1) ? 8 : 256);
      localparam logic [23:0] BA = (g == 0) ? 24'h000000 : ((g == 1) ? 24'hFFFFFC : 24'h000100);

      logic [15:0] spram_addr;
      logic [31:0] spram_rdat;
      logic        miso = 1'b0;
      logic [63:0] sh = '0;
      logic [31:0] cur_hdr = '0;
      logic [31:0] rd_word;
      logic        prev_sclk = 1'b0;
      logic        prev_sel = 1'b1;
      int          nbits = 0;
      int          wr_cnt = 0;
      int          rd_cnt = 0;
      int          partial = 0;
      logic [63:0] wr_log [0:127];
      logic [31:0] ram [0:511];
`ifdef SPRAM_FLUSH_VERIFY_EN
      logic        verify_err;
      logic [23:0] err_addr;
`endif

      spram_flush #(
         .NUM_BYTES (NB),
         .BASE_ADDR (BA)
      ) dut (
         .clk         (clk),
         .rst         (rst),
         .start       (start[g]),
         .busy        (busy[g]),
         .done        (done[g]),
         .spram_addr  (spram_addr),
         .spram_rdat  (spram_rdat),
         .spi_miso    (miso),
         .spi_select  (spi_select[g]),
         .spi_clk_out (spi_clk_out[g]),
         .spi_mosi    (spi_mosi[g])
`ifdef SPRAM_FLUSH_VERIFY_EN
         ,
         .verify_err  (verify_err),
         .err_addr    (err_addr)
`endif
      );

      always @(posedge clk) spram_rdat <= spram_mem[g][int'(spram_addr[7:2])];

      // SPI RAM slave: pre-edge values seen here are stable register outputs.
      always @(posedge clk) begin
         if (!spi_select[g] && spi_clk_out[g] && !prev_sclk) begin
            sh = {sh[62:0], spi_mosi[g]};
            nbits++;
            if (nbits == 32) cur_hdr = sh[31:0];
         end
         if (spi_select[g] && !prev_sel) begin
            if (nbits == 64) begin
               if (sh[63:56] == 8'h02) begin
                  if (wr_cnt < 128) wr_log[wr_cnt] = sh;
                  wr_cnt++;
                  ram[sh[42:34]] = sh[31:0];
               end else begin
                  rd_cnt++;
               end
            end else begin
               partial++;
            end
            nbits = 0;
         end
         prev_sclk = spi_clk_out[g];
         prev_sel  = spi_select[g];
      end

      // Read data changes while the SPI clock is low; word 0x000008 of instance 0 is corrupted.
      always @(negedge clk) begin
         if (!spi_select[g] && cur_hdr[31:24] == 8'h03 && nbits >= 32 && nbits < 64) begin
            rd_word = ram[cur_hdr[10:2]];
            if (g == 0 && cur_hdr[23:0] == 24'h000008) rd_word = rd_word ^ 32'h0000_0100;
            miso = rd_word[63 - nbits];
         end else begin
            miso = 1'b0;
         end
      end
   end

   function automatic logic [31:0] rev32(input logic [31:0] d);
      logic [31:0] r;
      for (int i = 0; i < 32; i++) r[31 - i] = d[i];
      return r;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Pulses start for instance k and waits (bounded) for done or for cycle stop_at.
   task automatic run_flush(input int k, input int stop_at, input int inj_a, input int inj_b,
                            output int cycles, output logic first_busy);
      start[k] = 1'b1;
      @(posedge clk);
      #1;
      start[k]   = 1'b0;
      cycles     = 0;
      first_busy = busy[k] & ~done[k];
      while (done[k] !== 1'b1 && cycles < 20000 && cycles != stop_at) begin
         start[k] = (cycles == inj_a || cycles == inj_b);
         @(posedge clk);
         #1;
         cycles++;
         if (busy[k] && done[k]) overlap++;
      end
      start[k] = 1'b0;
   endtask

   int   cyc;
   int   mism;
   logic fb;

   initial begin
      rst   = 1'b1;
      start = '0;
      spram_mem[0][0] = 32'h00000001;
      spram_mem[0][1] = 32'h80000000;
      spram_mem[0][2] = 32'hDEADBEEF;
      spram_mem[0][3] = 32'h12345678;
      spram_mem[1][0] = 32'hA5A5A5A5;
      spram_mem[1][1] = 32'h0000FFFF;
      for (int i = 0; i < 64; i++) spram_mem[2][i] = $urandom;
      repeat (3) @(posedge clk);
      #1;
      check("reset_outputs", {busy[0], done[0], spi_select[0], spi_clk_out[0], spi_mosi[0]},
            5'b00100);
      check("reset_spram_addr", u[0].spram_addr, 16'h0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Four-word flush with start pulses during SHIFT and in the cycle done rises.
      run_flush(0, -1, 60, 4 * W - 1, cyc, fb);
      check("busy_after_start", fb, 1'b1);
      check("cycles_to_done", cyc, 4 * W);
      check("done_busy_end", {done[0], busy[0]}, 2'b10);
      check("write_count", u[0].wr_cnt, 4);
      check("txn0", u[0].wr_log[0], 64'h02_000000_80000000);
      check("txn1", u[0].wr_log[1], 64'h02_000004_00000001);
      check("txn2", u[0].wr_log[2], 64'h02_000008_F77DB57B);
      check("txn3", u[0].wr_log[3], 64'h02_00000C_1E6A2C48);
`ifdef SPRAM_FLUSH_VERIFY_EN
      check("read_count", u[0].rd_cnt, 4);
      check("verify_err", u[0].verify_err, 1'b1);
      check("err_addr", u[0].err_addr, 24'h000008);
`endif
      repeat (5) @(posedge clk);
      #1;
      check("ignored_start_done", {done[0], busy[0]}, 2'b10);
      check("ignored_start_count", u[0].wr_cnt, 4);
      check("ignored_start_offset", u[0].spram_addr, 16'd12);

      // Reset during bit 20 of the second word, then restart from offset 0.
      run_flush(0, W + 43, -1, -1, cyc, fb);
      check("mid_txn_select", spi_select[0], 1'b0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("rst_select_busy_done", {spi_select[0], busy[0], done[0]}, 3'b100);
      @(posedge clk);
      #1;
      check("rst_partial", u[0].partial, 1);
      check("rst_write_count", u[0].wr_cnt, 5);
      run_flush(0, -1, -1, -1, cyc, fb);
      check("restart_cycles", cyc, 4 * W);
      check("restart_first_txn", u[0].wr_log[5], 64'h02_000000_80000000);
      check("restart_write_count", u[0].wr_cnt, 9);

      // 24-bit address wrap.
      run_flush(1, -1, -1, -1, cyc, fb);
      check("wrap_cycles", cyc, 2 * W);
      check("wrap_done", done[1], 1'b1);
      check("wrap_count", u[1].wr_cnt, 2);
      check("wrap_addr0", u[1].wr_log[0][55:32], 24'hFFFFFC);
      check("wrap_addr1", u[1].wr_log[1][55:32], 24'h000000);
      check("wrap_data1", u[1].wr_log[1][31:0], 32'hFFFF0000);

      // Round trip: reload from the SPI RAM image with the loader's bit order.
      run_flush(2, -1, -1, -1, cyc, fb);
      check("rt_cycles", cyc, 64 * W);
      check("rt_count", u[2].wr_cnt, 64);
      mism = 0;
      for (int i = 0; i < 64; i++) begin
         if (rev32(u[2].ram[64 + i]) !== spram_mem[2][i]) mism++;
      end
      check("rt_mismatches", mism, 0);
      check("busy_done_overlap", overlap, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
